detector_jogada: RTL and testbench

Receiving end of the player switch interface. It samples the asynchronous `chaves` inputs the player drives and debounces them. It then validates that exactly one switch is pressed and delivers a single registered `jogada_feita` pulse with the captured value to the game datapath/FSM. After each play it waits for the switches to be released before accepting the next one.

---
 rtl/jogo_pkg.sv | 13 +
 rtl/sincronizador_2ff.sv | 26 ++
 rtl/detector_jogada.sv | 165 ++++++++++++++++
 tb/tb_detector_jogada.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the player-switch receiver: FSM state codes
// (also exported on db_estado) and the debug state width.
package jogo_pkg;

  localparam int DB_ESTADO_W = 3;

  localparam logic [DB_ESTADO_W-1:0] OCIOSO       = 3'd0;
  localparam logic [DB_ESTADO_W-1:0] FILTRA       = 3'd1;
  localparam logic [DB_ESTADO_W-1:0] CAPTURA      = 3'd2;
  localparam logic [DB_ESTADO_W-1:0] INVALIDA     = 3'd3;
  localparam logic [DB_ESTADO_W-1:0] ESPERA_SOLTA = 3'd4;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for the asynchronous player switches.
// Each bit is synchronized independently; a multi-bit change may land
// across two cycles, which the downstream debounce filter absorbs.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // metastability stage followed by the stable output stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Player switch receiver: synchronizes and debounces the switches, accepts
// a play only when exactly one switch is pressed, and waits for release
// before re-arming.
// Optional idle timeout is built when JOGADA_TIMEOUT_EN is defined; otherwise
// timeout is tied low and no counter exists.
//
// state        | meaning
// OCIOSO       | idle, waiting for habilita and a nonzero switch value
// FILTRA       | debouncing: value must hold DEBOUNCE more cycles
// CAPTURA      | one cycle: valid one-hot play, jogada_feita pulses
// INVALIDA     | one cycle: stable but not one-hot, jogada_invalida pulses
// ESPERA_SOLTA | waiting for RELEASE consecutive all-zero cycles
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 3,
  parameter int RELEASE  = 2,
  parameter int TIMEOUT  = 5000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       chaves,
  input  logic                   habilita,
  input  logic                   limpa,
  output logic                   jogada_feita,
  output logic                   jogada_invalida,
  output logic [WIDTH-1:0]       jogada,
  output logic                   timeout,
  output logic [DB_ESTADO_W-1:0] db_estado
);

  localparam int DB_W  = $clog2(DEBOUNCE) + 1;
  localparam int REL_W = $clog2(RELEASE) + 1;
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE);
  localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE);

  logic [WIDTH-1:0]       chaves_s;
  logic [DB_ESTADO_W-1:0] estado, estado_next;
  logic [WIDTH-1:0]       amostra, amostra_next;
  logic [DB_W-1:0]        cnt, cnt_next;
  logic [REL_W-1:0]       rel_cnt, rel_next;

  sincronizador_2ff #(.WIDTH(WIDTH)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (chaves),
    .q     (chaves_s)
  );

  // next-state, sample and counter logic; limpa overrides everything
  always_comb begin
    estado_next  = estado;
    amostra_next = amostra;
    cnt_next     = cnt;
    rel_next     = rel_cnt;
    if (limpa) begin
      estado_next  = OCIOSO;
      amostra_next = '0;
      cnt_next     = '0;
      rel_next     = '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (habilita && chaves_s != '0) begin
            amostra_next = chaves_s;
            cnt_next     = DB_W'(1);
            estado_next  = FILTRA;
          end
        end
        FILTRA: begin
          if (!habilita || chaves_s == '0) begin
            estado_next = OCIOSO;
            cnt_next    = '0;
          end else if (chaves_s != amostra) begin
            // value moved: restart the filter on the new value
            amostra_next = chaves_s;
            cnt_next     = DB_W'(1);
          end else if (cnt == DB_MAX) begin
            estado_next = $onehot(amostra) ? CAPTURA : INVALIDA;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt + DB_W'(1);
          end
        end
        CAPTURA, INVALIDA: begin
          estado_next = ESPERA_SOLTA;
          rel_next    = '0;
        end
        ESPERA_SOLTA: begin
          if (chaves_s != '0) begin
            rel_next = '0;
          end else if (rel_cnt == REL_MAX - REL_W'(1)) begin
            rel_next    = '0;
            estado_next = OCIOSO;
          end else begin
            rel_next = rel_cnt + REL_W'(1);
          end
        end
        default: begin
          estado_next  = OCIOSO;
          amostra_next = '0;
          cnt_next     = '0;
          rel_next     = '0;
        end
      endcase
    end
  end

  // state, counters and registered Moore pulses; jogada loads together with the pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= OCIOSO;
      amostra         <= '0;
      cnt             <= '0;
      rel_cnt         <= '0;
      jogada          <= '0;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      estado          <= estado_next;
      amostra         <= amostra_next;
      cnt             <= cnt_next;
      rel_cnt         <= rel_next;
      jogada_feita    <= (estado_next == CAPTURA);
      jogada_invalida <= (estado_next == INVALIDA);
      if (limpa)
        jogada <= '0;
      else if (estado_next == CAPTURA)
        jogada <= amostra;
    end
  end

  assign db_estado = estado;

`ifdef JOGADA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt;

  // idle timer: runs only while idle and enabled, pulses and restarts at TIMEOUT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (limpa || !habilita || estado != OCIOSO || estado_next != OCIOSO) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_MAX - TO_W'(1)) begin
        to_cnt  <= '0;
        timeout <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada. Inputs change 1 time unit after a
// rising edge; outputs are observed at that same point.
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] chaves;
  logic       habilita;
  logic       limpa;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [3:0] jogada;
  logic       timeout;
  logic [2:0] db_estado;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  detector_jogada #(.WIDTH(4), .DEBOUNCE(3), .RELEASE(2), .TIMEOUT(20)) dut (
    .clock           (clock),
    .reset           (reset),
    .chaves          (chaves),
    .habilita        (habilita),
    .limpa           (limpa),
    .jogada_feita    (jogada_feita),
    .jogada_invalida (jogada_invalida),
    .jogada          (jogada),
    .timeout         (timeout),
    .db_estado       (db_estado)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; chaves = 4'b0000; habilita = 1'b0; limpa = 1'b0;
    tick(); tick();
    total++;
    if ({db_estado, jogada_feita, jogada_invalida, jogada, timeout} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs: got estado=%0d feita=%b inv=%b jogada=%b to=%b want all 0",
               db_estado, jogada_feita, jogada_invalida, jogada, timeout);
    end
    reset = 1'b1; habilita = 1'b1; chaves = 4'b0001;
    tick(); tick(); tick();
    total++;
    if (db_estado !== 3'd1) begin
      bad++; $display("FAIL reset_reach_filtra: got %0d want 1", db_estado);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({db_estado, jogada_feita, jogada_invalida, jogada, timeout} !== 10'd0) begin
      bad++;
      $display("FAIL reset_async: got estado=%0d feita=%b inv=%b jogada=%b want all 0",
               db_estado, jogada_feita, jogada_invalida, jogada);
    end
    chaves = 4'b0000;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (jogada !== 4'b0000 || db_estado !== 3'd0) begin
      bad++; $display("FAIL reset_after_release: got jogada=%b estado=%0d want 0000/0", jogada, db_estado);
    end
  endtask

  task automatic test_valid_press();
    int pulses;
    chaves = 4'b0100;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (jogada_feita !== 1'b0) begin
      bad++; $display("FAIL valid_early: got feita=%b want 0 after 5 edges", jogada_feita);
    end
    tick();
    total++;
    if (jogada_feita !== 1'b1 || jogada !== 4'b0100) begin
      bad++; $display("FAIL valid_pulse: got feita=%b jogada=%b want 1/0100 after 6 edges", jogada_feita, jogada);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (jogada_feita) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL valid_held_no_repeat: got %0d extra pulses want 0", pulses);
    end
    total++;
    if (db_estado !== 3'd4 || jogada !== 4'b0100) begin
      bad++; $display("FAIL valid_wait_release: got estado=%0d jogada=%b want 4/0100", db_estado, jogada);
    end
    chaves = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (db_estado !== 3'd0) begin
      bad++; $display("FAIL valid_rearm: got estado=%0d want 0", db_estado);
    end
  endtask

  task automatic test_short_press();
    int pulses;
    chaves = 4'b0010;
    tick(); tick(); tick();
    chaves = 4'b0000;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (jogada_feita || jogada_invalida) pulses++;
    end
    total++;
    if (pulses !== 0 || db_estado !== 3'd0 || jogada !== 4'b0100) begin
      bad++; $display("FAIL short_press: got pulses=%0d estado=%0d jogada=%b want 0/0/0100",
                      pulses, db_estado, jogada);
    end
  endtask

  task automatic test_invalid_then_valid();
    int inv;
    int ok;
    chaves = 4'b0011;
    inv = 0; ok = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (jogada_invalida) inv++;
      if (jogada_feita) ok++;
    end
    total++;
    if (inv !== 1 || ok !== 0) begin
      bad++; $display("FAIL invalid_pulse: got invalida=%0d feita=%0d want 1/0", inv, ok);
    end
    total++;
    if (jogada !== 4'b0100 || db_estado !== 3'd4) begin
      bad++; $display("FAIL invalid_keeps_jogada: got jogada=%b estado=%0d want 0100/4", jogada, db_estado);
    end
    chaves = 4'b0000;
    tick(); tick();
    chaves = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (jogada_feita !== 1'b0) begin
      bad++; $display("FAIL after_invalid_early: got feita=%b want 0", jogada_feita);
    end
    tick();
    total++;
    if (jogada_feita !== 1'b1 || jogada !== 4'b1000) begin
      bad++; $display("FAIL after_invalid_valid: got feita=%b jogada=%b want 1/1000", jogada_feita, jogada);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    chaves = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (db_estado !== 3'd0) begin
      bad++; $display("FAIL b2b_idle: got estado=%0d want 0", db_estado);
    end
    chaves = 4'b0001;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (jogada_feita) pulses++; end
    total++;
    if (pulses !== 1 || jogada !== 4'b0001) begin
      bad++; $display("FAIL b2b_first: got pulses=%0d jogada=%b want 1/0001", pulses, jogada);
    end
    chaves = 4'b0000;
    tick();
    chaves = 4'b0001;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (jogada_feita) pulses++; end
    total++;
    if (pulses !== 0 || db_estado !== 3'd4) begin
      bad++; $display("FAIL b2b_short_release: got pulses=%0d estado=%0d want 0/4", pulses, db_estado);
    end
    chaves = 4'b0000;
    tick(); tick();
    chaves = 4'b0001;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (jogada_feita) pulses++; end
    total++;
    if (pulses !== 1 || jogada !== 4'b0001) begin
      bad++; $display("FAIL b2b_second: got pulses=%0d jogada=%b want 1/0001", pulses, jogada);
    end
  endtask

  task automatic test_limpa();
    chaves = 4'b0000; habilita = 1'b0; limpa = 1'b1;
    tick();
    total++;
    if (db_estado !== 3'd0 || jogada !== 4'b0000 || jogada_feita !== 1'b0 || jogada_invalida !== 1'b0) begin
      bad++; $display("FAIL limpa: got estado=%0d jogada=%b feita=%b inv=%b want 0/0000/0/0",
                      db_estado, jogada, jogada_feita, jogada_invalida);
    end
    limpa = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    int errs;
    logic exp;
    habilita = 1'b0; chaves = 4'b0000;
    tick();
    habilita = 1'b1;
    errs = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
`ifdef JOGADA_TIMEOUT_EN
      exp = (i == 20 || i == 40);
`else
      exp = 1'b0;
`endif
      if (timeout !== exp) begin
        errs++;
        $display("FAIL timeout_enabled cycle %0d: got %b want %b", i, timeout, exp);
      end
    end
    total++;
    if (errs != 0) bad++;
    habilita = 1'b0;
    errs = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (timeout !== 1'b0) begin
        errs++;
        $display("FAIL timeout_disabled cycle %0d: got %b want 0", i, timeout);
      end
    end
    total++;
    if (errs != 0) bad++;
  endtask

  initial begin
    test_reset();
    test_valid_press();
    test_short_press();
    test_invalid_then_valid();
    test_back_to_back();
    test_limpa();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
